// File: rtl/icache_pkg.sv
// Shared widths, flush FSM encoding and address-slicing helpers for the icache.
package icache_pkg;

  localparam int INDEX_W_DEF = 7;
  localparam int ADDR_W_DEF  = 32;
  localparam int TAG_W       = ADDR_W_DEF - INDEX_W_DEF - 2;
  localparam int DATA_W      = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Right-justified index/tag of a byte address for a given index width.
  function automatic logic [ADDR_W_DEF-1:0] addr_index(input logic [ADDR_W_DEF-1:0] addr,
                                                      input int index_w);
    return (addr >> 2) & ((ADDR_W_DEF'(1) << index_w) - ADDR_W_DEF'(1));
  endfunction

  function automatic logic [ADDR_W_DEF-1:0] addr_tag(input logic [ADDR_W_DEF-1:0] addr,
                                                    input int index_w);
    return addr >> (index_w + 2);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side bus of the icache; hit_cnt_o/miss_cnt_o exist only with ICACHE_STATS_EN.
interface icache_if #(
  parameter int ADDR_W = icache_pkg::ADDR_W_DEF
);
  logic              read_i;
  logic [ADDR_W-1:0] read_addr_i;
  logic              read_hit_o;
  logic [31:0]       read_inst_o;
  logic              write_i;
  logic [ADDR_W-1:0] write_addr_i;
  logic [31:0]       write_inst_i;
  logic              flush_i;
  logic              busy_o;
`ifdef ICACHE_STATS_EN
  logic [31:0]       hit_cnt_o;
  logic [31:0]       miss_cnt_o;
`endif

  modport master (
    output read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
    input  read_hit_o, read_inst_o, busy_o
`ifdef ICACHE_STATS_EN
    , hit_cnt_o, miss_cnt_o
`endif
  );

  modport slave (
    input  read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
    output read_hit_o, read_inst_o, busy_o
`ifdef ICACHE_STATS_EN
    , hit_cnt_o, miss_cnt_o
`endif
  );
endinterface

// File: rtl/icache_wbuf.sv
// One-entry fill buffer: holds a fill for one cycle, then presents it for commit,
// while offering a same-word bypass match to the probe path.
module icache_wbuf
  import icache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [ADDR_W-1:2] capture_addr,
  input  logic [31:0]       capture_inst,
  input  logic              drop,
  input  logic [ADDR_W-1:2] probe_addr,
  output logic              commit,
  output logic [ADDR_W-1:2] commit_addr,
  output logic [31:0]       commit_inst,
  output logic              match,
  output logic [31:0]       match_inst
);

  logic              valid_reg;
  logic [ADDR_W-1:2] addr_reg;
  logic [31:0]       inst_reg;

  // Occupancy lasts exactly one cycle unless refilled, so a new capture can
  // overwrite the entry in the same cycle it commits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
    end else if (drop) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !drop) begin
      addr_reg <= capture_addr;
      inst_reg <= capture_inst;
    end
  end

  assign commit      = valid_reg && !drop;
  assign commit_addr = addr_reg;
  assign commit_inst = inst_reg;
  assign match       = valid_reg && (addr_reg == probe_addr);
  assign match_inst  = inst_reg;

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache with fill buffer bypass and a
// sweeping invalidate-all sequencer. Define ICACHE_STATS_EN for hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);

  localparam int LINES  = 1 << INDEX_W;
  localparam int TAG_BW = ADDR_W - INDEX_W - 2;
  localparam logic [INDEX_W-1:0] LAST_LINE = '1;

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] cnt_reg, cnt_next;
  logic               busy;
  logic               flush_start;
  logic               capture;

  logic [LINES-1:0]   valid_reg;
  logic [TAG_BW-1:0]  tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic               commit;
  logic [ADDR_W-1:2]  commit_addr;
  logic [31:0]        commit_inst;
  logic [INDEX_W-1:0] commit_idx;
  logic [TAG_BW-1:0]  commit_tag;
  logic               wb_match;
  logic [31:0]        wb_inst;

  logic [INDEX_W-1:0] rd_idx;
  logic [TAG_BW-1:0]  rd_tag;
  logic               arr_hit;
  logic               hit;
  logic               unused_addr_bits;

  assign busy        = (state_reg == ST_FLUSH);
  assign flush_start = bus.flush_i && !busy;
  // Fills are lost while sweeping and in the cycle that starts a sweep.
  assign capture     = bus.write_i && !busy && !flush_start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.flush_i) begin
          state_next = ST_FLUSH;
          cnt_next   = '0;
        end
      end
      ST_FLUSH: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_LINE) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  icache_wbuf #(
    .ADDR_W(ADDR_W)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .capture_addr(bus.write_addr_i[ADDR_W-1:2]),
    .capture_inst(bus.write_inst_i),
    .drop        (flush_start),
    .probe_addr  (bus.read_addr_i[ADDR_W-1:2]),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_inst (commit_inst),
    .match       (wb_match),
    .match_inst  (wb_inst)
  );

  assign commit_idx = commit_addr[INDEX_W+1:2];
  assign commit_tag = commit_addr[ADDR_W-1:INDEX_W+2];

  // Tag/data need no reset: every use is qualified by the line's valid bit.
  always_ff @(posedge clk) begin
    if (commit) begin
      tag_mem[commit_idx]  <= commit_tag;
      data_mem[commit_idx] <= commit_inst;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (busy && (cnt_reg == INDEX_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end else if (commit && (commit_idx == INDEX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign rd_idx  = bus.read_addr_i[INDEX_W+1:2];
  assign rd_tag  = bus.read_addr_i[ADDR_W-1:INDEX_W+2];
  assign arr_hit = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign hit     = bus.read_i && !busy && (wb_match || arr_hit);

  assign bus.read_hit_o  = hit;
  assign bus.read_inst_o = !hit ? 32'd0 : (wb_match ? wb_inst : data_mem[rd_idx]);
  assign bus.busy_o      = busy;

  assign unused_addr_bits = ^{bus.read_addr_i[1:0], bus.write_addr_i[1:0]};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;
  logic        counted;

  assign counted = bus.read_i && !busy;

  // Saturating; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (counted) begin
      if (hit) begin
        if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end else begin
        if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.hit_cnt_o  = hit_cnt_reg;
  assign bus.miss_cnt_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random traffic against a
// line-map reference model.
module tb_icache;

  logic clk;
  logic rst;

  icache_if bus ();

  icache u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: committed lines, the fill waiting to land, flush time left.
  bit          mv    [128];
  logic [31:0] mtag  [128];
  logic [31:0] mdata [128];
  bit          pend_v = 0;
  logic [31:0] pend_word = 0;
  logic [31:0] pend_inst = 0;
  int          busy_left = 0;
  int          st_hits = 0;
  int          st_misses = 0;

  logic        obs_hit;
  logic [31:0] obs_inst;
  logic        obs_busy;
  logic [31:0] obs_hcnt;
  logic [31:0] obs_mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) mv[i] = 0;
    pend_v = 0;
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance the model.
  task automatic step(input bit r, input logic [31:0] ra, input bit w, input logic [31:0] wa,
                      input logic [31:0] wi, input bit f, input bit rs);
    bit          exp_hit;
    logic [31:0] exp_inst;
    int          idx;
    bus.read_i       = r;
    bus.read_addr_i  = ra;
    bus.write_i      = w;
    bus.write_addr_i = wa;
    bus.write_inst_i = wi;
    bus.flush_i      = f;
    rst              = rs;
    @(negedge clk);
    idx      = int'((ra >> 2) % 128);
    exp_hit  = 0;
    exp_inst = 0;
    if (r && busy_left == 0) begin
      if (pend_v && pend_word == (ra >> 2)) begin
        exp_hit = 1; exp_inst = pend_inst;
      end else if (mv[idx] && mtag[idx] == (ra >> 9)) begin
        exp_hit = 1; exp_inst = mdata[idx];
      end
    end
    obs_hit  = bus.read_hit_o;
    obs_inst = bus.read_inst_o;
    obs_busy = bus.busy_o;
    chk("hit", {31'd0, obs_hit}, {31'd0, exp_hit});
    chk("inst", obs_inst, exp_inst);
    chk("busy", {31'd0, obs_busy}, (busy_left > 0) ? 32'd1 : 32'd0);
`ifdef ICACHE_STATS_EN
    obs_hcnt = bus.hit_cnt_o;
    obs_mcnt = bus.miss_cnt_o;
    chk("hit_cnt", obs_hcnt, st_hits);
    chk("miss_cnt", obs_mcnt, st_misses);
`endif
    @(posedge clk);
    if (!rs) begin
      model_clear();
      busy_left = 0;
      st_hits   = 0;
      st_misses = 0;
    end else begin
      if (r && busy_left == 0) begin
        if (exp_hit) st_hits++; else st_misses++;
      end
      if (busy_left > 0) begin
        busy_left--;
      end else if (f) begin
        busy_left = 128;
        model_clear();
      end else begin
        if (pend_v) begin
          mv[pend_word % 128]    = 1;
          mtag[pend_word % 128]  = pend_word >> 7;
          mdata[pend_word % 128] = pend_inst;
        end
        pend_v    = w;
        pend_word = wa >> 2;
        pend_inst = wi;
      end
    end
    #1;
  endtask

  task automatic probe(input logic [31:0] a);
    step(1, a, 0, 0, 0, 0, 1);
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    step(0, 0, 1, a, d, 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    logic [31:0] idx;
    logic [31:0] tg;
    sel = $urandom_range(0, 6);
    idx = (sel == 6) ? 32'd127 : 32'(sel);
    tg  = 32'($urandom_range(0, 2));
    return (tg << 9) | (idx << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int nbusy;
    bit done;
    bus.read_i = 0; bus.read_addr_i = 0; bus.write_i = 0;
    bus.write_addr_i = 0; bus.write_inst_i = 0; bus.flush_i = 0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;

    // Cold cache
    probe(32'h100);
    chk("rst_hit", {31'd0, obs_hit}, 32'd0);
    chk("rst_inst", obs_inst, 32'd0);

    // Bypass then array hit
    fill(32'h100, 32'h13);
    probe(32'h100);
    chk("bypass_inst", obs_inst, 32'h13);
    idle(1);
    probe(32'h100);
    chk("array_hit", {31'd0, obs_hit}, 32'd1);
    chk("array_inst", obs_inst, 32'h13);

    // Read and write to the same word in one cycle
    step(1, 32'h180, 1, 32'h180, 32'hABCD, 0, 1);
    chk("same_cycle_miss", {31'd0, obs_hit}, 32'd0);
    probe(32'h180);
    chk("same_cycle_next", obs_inst, 32'hABCD);

    // Tag conflict
    fill(32'h104, 32'h1111_1111);
    idle(2);
    probe(32'h304);
    chk("alias_miss", {31'd0, obs_hit}, 32'd0);
    fill(32'h304, 32'hFFDF_F06F);
    idle(2);
    probe(32'h104);
    chk("evicted_miss", {31'd0, obs_hit}, 32'd0);
    probe(32'h304);
    chk("new_tag_inst", obs_inst, 32'hFFDF_F06F);

    // Back-to-back fills
    fill(32'h0, 32'hA0);
    fill(32'h4, 32'hA4);
    idle(1);
    probe(32'h0);
    chk("b2b_first", obs_inst, 32'hA0);
    probe(32'h4);
    chk("b2b_second", obs_inst, 32'hA4);

    // Flush: length, misses while busy, dropped write, ignored re-flush
    for (int i = 0; i < 5; i++) fill(32'h200 + 4 * i, 32'h5000 + i);
    idle(2);
    probe(32'h208);
    chk("pre_flush_hit", obs_inst, 32'h5002);
    step(1, 32'h200, 0, 0, 0, 1, 1);
    nbusy = 0;
    done  = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (k == 10) step(1, 32'h204, 1, 32'h220, 32'h77, 0, 1);
      else if (k == 20) step(1, 32'h208, 0, 0, 0, 1, 1);
      else step(1, 32'h200 + 4 * (k % 5), 0, 0, 0, 0, 1);
      if (obs_busy) nbusy++; else done = 1;
    end
    chk("flush_len", nbusy, 32'd128);
    for (int i = 0; i < 5; i++) begin
      probe(32'h200 + 4 * i);
      chk("post_flush_miss", {31'd0, obs_hit}, 32'd0);
    end
    probe(32'h220);
    chk("dropped_write", {31'd0, obs_hit}, 32'd0);

    // Reset in the middle of a sweep, and with a fill pending
    step(0, 0, 0, 0, 0, 1, 1);
    idle(40);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("rst_midflush_busy", {31'd0, obs_busy}, 32'd0);
    fill(32'h140, 32'h99);
    step(0, 0, 0, 0, 0, 0, 0);
    probe(32'h140);
    chk("rst_drops_pending", {31'd0, obs_hit}, 32'd0);

`ifdef ICACHE_STATS_EN
    step(0, 0, 0, 0, 0, 0, 0);
    fill(32'h100, 32'h13);
    idle(1);
    probe(32'h100); probe(32'h100); probe(32'h100);
    probe(32'h500); probe(32'h104);
    idle(1);
    chk("stats_hits", obs_hcnt, 32'd3);
    chk("stats_misses", obs_mcnt, 32'd2);
    step(0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 128; k++) probe(32'h100);
    idle(1);
    chk("stats_hits_flush", obs_hcnt, 32'd3);
    chk("stats_misses_flush", obs_mcnt, 32'd2);
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 1) == 1, rand_addr(), ($urandom % 3) == 0, rand_addr(), $urandom,
           ($urandom % 64) == 0, ($urandom % 200) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
